// File: rtl/rio_link_tx_ctrl.sv
// -----------------------------------------------------------------------------
// rio_link_tx_ctrl
//
// Transmit-side link controller for a RocketIO serial lane. It runs the
// TRN/ACK bring-up handshake with the peer and then forwards user words to
// the GTP TX data/charisk ports. When no user word is available it sends IDLE,
// and optionally a periodic clock-correction word. It falls back to training
// on receive loss, a peer retrain, or a rising edge of the link error flag.
//
// Optional feature macro: RIO_TX_CC_EN
//   defined   - a CC word (1C1C/11) is sent every CC_PERIOD cycles while UP,
//               with o_user_ready held low in the cycle the CC is chosen
//   undefined - no CC counter is built and CC is never sent
//
// Ports
//   clk              in   single clock
//   rst_n            in   asynchronous active-low reset
//   i_rx_up          in   local receiver aligned/locked
//   i_rx_peer_state  in   [1:0] 0 none, 1 peer sends TRN, 2 peer sends ACK/idle/data
//   i_link_error     in   sticky receive-side error flag (rising edge acted on)
//   i_user_data      in   [15:0] user word
//   i_user_valid     in   user word valid
//   o_user_ready     out  user word accepted this cycle (registered)
//   o_tx_data        out  [15:0] GTP TX data (registered)
//   o_tx_charisk     out  [1:0] GTP TX K flags, bit 1 qualifies data[15:8]
//   o_tx_up          out  link is UP (registered)
// -----------------------------------------------------------------------------
module rio_link_tx_ctrl #(
  parameter int unsigned TRAIN_CYCLES    = 1024,
  parameter int unsigned ACK_CYCLES      = 64,
  parameter int unsigned ERR_HOLD_CYCLES = 256,
  parameter int unsigned CC_PERIOD       = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_up,
  input  logic [1:0]  i_rx_peer_state,
  input  logic        i_link_error,
  input  logic [15:0] i_user_data,
  input  logic        i_user_valid,
  output logic        o_user_ready,
  output logic [15:0] o_tx_data,
  output logic [1:0]  o_tx_charisk,
  output logic        o_tx_up
);

  localparam int unsigned MAX_TA  = (TRAIN_CYCLES > ACK_CYCLES) ? TRAIN_CYCLES : ACK_CYCLES;
  localparam int unsigned MAX_TAE = (MAX_TA > ERR_HOLD_CYCLES) ? MAX_TA : ERR_HOLD_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_TAE > CC_PERIOD) ? MAX_TAE : CC_PERIOD;
  localparam int          CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ERR_HOLD_CYCLES - 1);

  localparam logic [15:0] TRN_DATA  = 16'hBC4A;
  localparam logic [15:0] ACK_DATA  = 16'hBCB5;
  localparam logic [15:0] IDLE_DATA = 16'hBC50;
  localparam logic [15:0] CC_DATA   = 16'h1C1C;
  localparam logic [1:0]  K_HI      = 2'b10;
  localparam logic [1:0]  K_BOTH    = 2'b11;
  localparam logic [1:0]  K_NONE    = 2'b00;

  localparam logic [1:0]  PEER_NONE = 2'd0;
  localparam logic [1:0]  PEER_TRN  = 2'd1;
  localparam logic [1:0]  PEER_OK   = 2'd2;

  typedef enum logic [1:0] {
    ST_ERR_HOLD = 2'd0,
    ST_TRAIN    = 2'd1,
    ST_ACK      = 2'd2,
    ST_UP       = 2'd3
  } state_t;

  // Counters never wrap: they stop at their terminal value until a
  // transition clears them.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    sat_inc = (v >= lim) ? lim : (v + CNT_W'(1));
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic [15:0]      tx_data_q, tx_data_d;
  logic [1:0]       tx_k_q, tx_k_d;
  logic             tx_up_q, tx_up_d;
  logic             ready_q, ready_d;

  logic             err_rise;
  logic             qualify;
  logic             accept;
  logic             cc_due;    // CC chosen this cycle (state_q is UP)
  logic             cc_due_d;  // CC will be due in the next cycle

  assign err_rise = i_link_error & ~err_q;
  assign qualify  = i_rx_up & (i_rx_peer_state != PEER_NONE);
  // ready_q is only ever high in UP, so it doubles as the UP qualifier.
  assign accept   = i_user_valid & ready_q;

`ifdef RIO_TX_CC_EN
  localparam logic [CNT_W-1:0] CC_LAST = CNT_W'(CC_PERIOD - 1);

  logic [CNT_W-1:0] cc_cnt_q, cc_cnt_d;

  assign cc_due = (state_q == ST_UP) && (cc_cnt_q == CC_LAST);

  // Runs only while staying in UP; any cycle outside UP (including the
  // entry cycle) leaves it at zero.
  always_comb begin
    cc_cnt_d = '0;
    if ((state_q == ST_UP) && (state_d == ST_UP)) begin
      cc_cnt_d = cc_due ? '0 : sat_inc(cc_cnt_q, CC_LAST);
    end
  end

  assign cc_due_d = (state_d == ST_UP) && (cc_cnt_d == CC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_cnt_q <= '0;
    end else begin
      cc_cnt_q <= cc_cnt_d;
    end
  end
`else
  assign cc_due   = 1'b0;
  assign cc_due_d = 1'b0;
`endif

  // Next state: link-loss exits take priority over everything, then a new
  // link error (ACK/UP only), then a peer retrain (UP only).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_rx_up) begin
      state_d = ST_TRAIN;
      cnt_d   = '0;
    end else if (((state_q == ST_ACK) || (state_q == ST_UP)) && err_rise) begin
      state_d = ST_ERR_HOLD;
      cnt_d   = '0;
    end else if ((state_q == ST_UP) && (i_rx_peer_state == PEER_TRN)) begin
      state_d = ST_TRAIN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_TRAIN: begin
          if (!qualify) begin
            cnt_d = '0;
          end else if (cnt_q == TRAIN_LAST) begin
            state_d = ST_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q, TRAIN_LAST);
          end
        end
        ST_ACK: begin
          if ((cnt_q == ACK_LAST) && (i_rx_peer_state == PEER_OK)) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q, ACK_LAST);
          end
        end
        ST_UP: begin
          cnt_d = '0;
        end
        ST_ERR_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q, HOLD_LAST);
          end
        end
        default: begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output word for the next cycle. An accepted user word always wins so a
  // word taken in the last UP cycle is still emitted; o_tx_up stays high for
  // that word and falls with the first TRN.
  always_comb begin
    tx_data_d = TRN_DATA;
    tx_k_d    = K_HI;
    if (accept) begin
      tx_data_d = i_user_data;
      tx_k_d    = K_NONE;
    end else begin
      case (state_d)
        ST_UP: begin
          tx_data_d = cc_due ? CC_DATA : IDLE_DATA;
          tx_k_d    = cc_due ? K_BOTH : K_HI;
        end
        ST_ACK: begin
          tx_data_d = ACK_DATA;
          tx_k_d    = K_HI;
        end
        default: begin
          tx_data_d = TRN_DATA;
          tx_k_d    = K_HI;
        end
      endcase
    end
    tx_up_d = (state_d == ST_UP) || accept;
    ready_d = (state_d == ST_UP) && !cc_due_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_TRAIN;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      tx_data_q <= TRN_DATA;
      tx_k_q    <= K_HI;
      tx_up_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= i_link_error;
      tx_data_q <= tx_data_d;
      tx_k_q    <= tx_k_d;
      tx_up_q   <= tx_up_d;
      ready_q   <= ready_d;
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_charisk = tx_k_q;
  assign o_tx_up      = tx_up_q;
  assign o_user_ready = ready_q;

endmodule

// File: tb/tb_rio_link_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rio_link_tx_ctrl
//
// Bench for rio_link_tx_ctrl. A behavioural model steps once per clock from
// the sampled inputs, tracking mode and "how many cycles so far" counts, and
// pushes the expected output word/flags into a queue; a monitor pops one
// entry per cycle and compares. Directed phases add run-length checks for
// the bring-up, error hold, receive loss, clock correction and async reset.
// Define RIO_TX_CC_EN for both bench and design to cover clock correction.
// -----------------------------------------------------------------------------
module tb_rio_link_tx_ctrl;

  localparam int TRAIN_CYCLES    = 1024;
  localparam int ACK_CYCLES      = 64;
  localparam int ERR_HOLD_CYCLES = 256;
  localparam int CC_PERIOD       = 5000;
`ifdef RIO_TX_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  localparam int M_ERR = 0, M_TRAIN = 1, M_ACK = 2, M_UP = 3;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        up;
    logic        rdy;
  } exp_t;

  localparam exp_t RESET_EXP = {16'hBC4A, 2'b10, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_up = 1'b1;
  logic [1:0]  peer = 2'd1;
  logic        link_error = 1'b0;
  logic [15:0] user_data = 16'h0000;
  logic        user_valid = 1'b0;
  logic        user_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic        tx_up;

  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  exp_t mon_act;
  exp_t mon_exp;

  // behavioural model state
  int m_mode;
  int m_run;      // cycles spent in the current phase (qualifying, for TRAIN)
  int m_age;      // cycles since entering UP
  bit m_ready;
  bit m_err_prev;

  always #5 clk = ~clk;

  rio_link_tx_ctrl #(
    .TRAIN_CYCLES    (TRAIN_CYCLES),
    .ACK_CYCLES      (ACK_CYCLES),
    .ERR_HOLD_CYCLES (ERR_HOLD_CYCLES),
    .CC_PERIOD       (CC_PERIOD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rx_up         (rx_up),
    .i_rx_peer_state (peer),
    .i_link_error    (link_error),
    .i_user_data     (user_data),
    .i_user_valid    (user_valid),
    .o_user_ready    (user_ready),
    .o_tx_data       (tx_data),
    .o_tx_charisk    (tx_k),
    .o_tx_up         (tx_up)
  );

  task automatic check(input string nm, input exp_t act, input exp_t req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @%0t: actual data=%h k=%b up=%b rdy=%b, required data=%h k=%b up=%b rdy=%b",
               nm, $time, act.d, act.k, act.up, act.rdy, req.d, req.k, req.up, req.rdy);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  task automatic model_init();
    m_mode     = M_TRAIN;
    m_run      = 0;
    m_age      = 0;
    m_ready    = 1'b0;
    m_err_prev = 1'b0;
  endtask

  // One clock of the link as the rules describe it: decide where the link
  // goes this cycle, then what word the next cycle carries.
  task automatic model_step();
    bit   acc, cc, rise;
    int   nxt, nage;
    exp_t e;
    acc  = (m_mode == M_UP) && user_valid && m_ready;
    cc   = CC_EN && (m_mode == M_UP) && ((m_age % CC_PERIOD) == CC_PERIOD - 1);
    rise = link_error && !m_err_prev;
    m_err_prev = link_error;
    nxt = m_mode;
    if (!rx_up) begin
      nxt   = M_TRAIN;
      m_run = 0;
    end else if ((m_mode == M_ACK || m_mode == M_UP) && rise) begin
      nxt = M_ERR;
    end else if (m_mode == M_UP && peer == 2'd1) begin
      nxt = M_TRAIN;
    end else begin
      case (m_mode)
        M_TRAIN: begin
          m_run = (peer != 2'd0) ? m_run + 1 : 0;
          if (m_run == TRAIN_CYCLES) nxt = M_ACK;
        end
        M_ACK: begin
          m_run++;
          if (m_run >= ACK_CYCLES && peer == 2'd2) nxt = M_UP;
        end
        M_ERR: begin
          m_run++;
          if (m_run == ERR_HOLD_CYCLES) nxt = M_TRAIN;
        end
        default: ;
      endcase
    end
    if (nxt != m_mode) m_run = 0;
    nage = (m_mode == M_UP && nxt == M_UP) ? m_age + 1 : 0;

    if (acc) begin
      e.d = user_data; e.k = 2'b00;
    end else if (nxt == M_UP) begin
      e.d = cc ? 16'h1C1C : 16'hBC50; e.k = cc ? 2'b11 : 2'b10;
    end else if (nxt == M_ACK) begin
      e.d = 16'hBCB5; e.k = 2'b10;
    end else begin
      e.d = 16'hBC4A; e.k = 2'b10;
    end
    e.up  = (nxt == M_UP) || acc;
    e.rdy = (nxt == M_UP) && !(CC_EN && ((nage % CC_PERIOD) == CC_PERIOD - 1));

    m_mode  = nxt;
    m_age   = nage;
    m_ready = e.rdy;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // Monitor: one output word per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    mon_act = {tx_data, tx_k, tx_up, user_ready};
    if (!rst_n) begin
      check("reset_value", mon_act, RESET_EXP);
    end else if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL sb_underflow @%0t: actual data=%h with no expected entry", $time, tx_data);
    end else begin
      mon_exp = exp_q.pop_front();
      check("sb_word", mon_act, mon_exp);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    model_init();
    exp_q.delete();
    exp_q.push_back(RESET_EXP);
    rst_n = 1'b1;
  endtask

  // Counts output cycles until word w appears (bounded), and how many of
  // those cycles had o_tx_up high.
  task automatic count_until(input logic [15:0] w, input int bound, output int n, output int ups);
    n = 0;
    ups = 0;
    @(negedge clk);
    while (tx_data != w && n < bound) begin
      n++;
      if (tx_up) ups++;
      @(negedge clk);
    end
  endtask

  task automatic wait_up(input int bound, output int ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_up && n < bound) begin
      n++;
      @(negedge clk);
    end
    ok = tx_up ? 1 : 0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog @%0t: actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ups, ok, n_cc, n_rlow;
    bit r;

    // Bring-up from reset with the peer training.
    model_init();
    do_reset();
    count_until(16'hBCB5, 3000, n, ups);
    check_int("train_len_reset", n, TRAIN_CYCLES);
    check_int("train_up_low", ups, 0);
    peer       = 2'd2;
    user_valid = 1'b1;
    user_data  = 16'h0001;
    count_until(16'hBC50, 500, n, ups);
    check_int("ack_len", n + 1, ACK_CYCLES);
    check_int("ack_up_low", ups, 0);

    // Continuous stream in UP, incrementing words from 0x0001.
    n_cc = 0;
    n_rlow = 0;
    for (int i = 0; i < 12000; i++) begin
      r = user_ready;
      if (tx_k == 2'b11 && tx_data == 16'h1C1C) n_cc++;
      if (tx_up && !r) n_rlow++;
      @(posedge clk);
      #2;
      if (r) user_data = user_data + 16'd1;
      @(negedge clk);
    end
    check_int("cc_count", n_cc, CC_EN ? 2 : 0);
    check_int("ready_low_count", n_rlow, CC_EN ? 2 : 0);

    // Link error in UP while the peer retrains.
    @(posedge clk); #2;
    user_valid = 1'b0;
    @(posedge clk); #2;
    link_error = 1'b1;
    peer       = 2'd1;
    @(posedge clk);
    count_until(16'hBCB5, 3000, n, ups);
    check_int("err_hold_plus_train", n, ERR_HOLD_CYCLES + TRAIN_CYCLES);
    check_int("err_up_low", ups, 0);

    // Error flag still high: must not block reaching UP.
    peer = 2'd2;
    wait_up(300, ok);
    check_int("up_with_level_error", ok, 1);

    // Peer retrain from UP.
    peer = 2'd1;
    count_until(16'hBCB5, 3000, n, ups);
    check_int("peer_retrain_len", n, TRAIN_CYCLES);

    // Receive loss for one cycle while ACK counter is at 30.
    repeat (30) @(posedge clk);
    #2;
    rx_up = 1'b0;
    @(posedge clk); #2;
    rx_up = 1'b1;
    count_until(16'hBCB5, 3000, n, ups);
    check_int("rx_drop_retrain_len", n, TRAIN_CYCLES);
    check_int("rx_drop_up_low", ups, 0);

    link_error = 1'b0;
    peer = 2'd2;
    wait_up(300, ok);
    check_int("up_after_rx_drop", ok, 1);

    // Randomized traffic with occasional disturbances.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      user_valid = 1'($urandom_range(0, 1));
      user_data  = 16'($urandom);
      rx_up      = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 499) == 0) link_error = ~link_error;
      if ($urandom_range(0, 399) == 0) peer = 2'($urandom_range(0, 2));
    end

    @(posedge clk); #2;
    rx_up      = 1'b1;
    peer       = 2'd2;
    link_error = 1'b0;
    user_valid = 1'b1;
    wait_up(3000, ok);
    check_int("up_after_random", ok, 1);
    repeat (20) begin
      @(posedge clk); #2;
      user_data = 16'($urandom);
    end

    // Asynchronous reset mid-transfer.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {tx_data, tx_k, tx_up, user_ready}, RESET_EXP);
    peer       = 2'd1;
    user_valid = 1'b0;
    do_reset();
    count_until(16'hBCB5, 3000, n, ups);
    check_int("train_len_after_reset", n, TRAIN_CYCLES);
    peer = 2'd2;
    wait_up(300, ok);
    check_int("up_after_reset", ok, 1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
